// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF neuron configuration path.
// Holds the serializer state encoding, the byte map of the parameter frame, and the counter-width helper.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } ser_state_t;

  // Byte positions in the parameter frame. The highest byte is sent first.
  localparam int BYTE_THRESHOLD = 3;
  localparam int BYTE_LEAK      = 2;
  localparam int BYTE_WEIGHT_A  = 1;
  localparam int BYTE_WEIGHT_B  = 0;

  localparam int DEFAULT_NUM_BYTES = 4;

  // Width of a counter that holds 0..n-1. It is never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lif_bit_timer.sv
// Bit-period divider: bit_tick is high in the last cycle of every BIT_DIV-cycle period while enabled.
// No added latency. restart reloads the period to cycle 0, and there is no backpressure.
module lif_bit_timer
  import lif_pkg::*;
#(
  parameter int BIT_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic bit_tick
);

  localparam int               DIV_W    = cnt_width(BIT_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign bit_tick = enable && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= bit_tick ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lif_param_serializer.sv
// MSB-first serial transmitter for LIF parameter frames, followed by an acknowledge wait with a timeout.
// Outputs are registered, and the first bit appears one cycle after the handshake. frame_ready is high only in IDLE, and offers made while busy are dropped.
module lif_param_serializer
  import lif_pkg::*;
#(
  parameter  int NUM_BYTES   = DEFAULT_NUM_BYTES,
  parameter  int BIT_DIV     = 1,
  parameter  int ACK_TIMEOUT = 64,
  localparam int FRAME_W     = 8 * NUM_BYTES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic               abort,
  output logic               load_mode,
  output logic               serial_data,
  input  logic               params_ready,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  localparam int              BC_W     = $clog2(FRAME_W + 1);
  localparam int              TO_W     = cnt_width(ACK_TIMEOUT);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(FRAME_W - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  ser_state_t         state;
  logic [FRAME_W-1:0] shreg;
  logic [BC_W-1:0]    bit_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               accept;
  logic               bit_tick;

  // frame_ready is a registered copy of (state == ST_IDLE).
  assign accept = frame_ready && frame_valid;

  lif_bit_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (accept),
    .enable   (state == ST_SHIFT),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      load_mode   <= 1'b0;
      serial_data <= 1'b0;
      frame_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_SHIFT;
            shreg       <= frame_data;
            bit_cnt     <= '0;
            load_mode   <= 1'b1;
            serial_data <= frame_data[FRAME_W-1];
            frame_ready <= 1'b0;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
          end
        end

        ST_SHIFT: begin
          // abort is checked first so that it also cancels the final-bit transition.
          if (abort) begin
            state       <= ST_IDLE;
            load_mode   <= 1'b0;
            serial_data <= 1'b0;
            frame_ready <= 1'b1;
            busy        <= 1'b0;
          end else if (bit_tick) begin
            if (bit_cnt == BIT_LAST) begin
              state       <= ST_WAIT_ACK;
              to_cnt      <= '0;
              shreg       <= '0;
              load_mode   <= 1'b0;
              serial_data <= 1'b0;
            end else begin
              bit_cnt     <= bit_cnt + 1'b1;
              shreg       <= {shreg[FRAME_W-2:0], 1'b0};
              serial_data <= shreg[FRAME_W-2];
            end
          end
        end

        ST_WAIT_ACK: begin
          if (abort) begin
            state       <= ST_IDLE;
            frame_ready <= 1'b1;
            busy        <= 1'b0;
          end else if (params_ready) begin
            state       <= ST_IDLE;
            done        <= 1'b1;
            frame_ready <= 1'b1;
            busy        <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            state       <= ST_IDLE;
            timeout_err <= 1'b1;
            frame_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          load_mode   <= 1'b0;
          serial_data <= 1'b0;
          frame_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lif_param_serializer.sv
// Bench for lif_param_serializer. One instance uses BIT_DIV=1 and ACK_TIMEOUT=64, and a second instance uses BIT_DIV=3.
// A scoreboard queue holds the expected bit stream of the first instance.
`timescale 1ns/1ps
module tb_lif_param_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        reset = 1'b1;
  logic [31:0] frame_data = '0;
  logic        frame_valid = 1'b0, abort = 1'b0, params_ready = 1'b0;
  logic        frame_ready, load_mode, serial_data, busy, done, timeout_err;

  logic [31:0] frame_data_b = '0;
  logic        frame_valid_b = 1'b0, abort_b = 1'b0, params_ready_b = 1'b0;
  logic        frame_ready_b, load_mode_b, serial_data_b, busy_b, done_b, timeout_err_b;

  lif_param_serializer #(.NUM_BYTES(4), .BIT_DIV(1), .ACK_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .abort(abort), .load_mode(load_mode), .serial_data(serial_data),
    .params_ready(params_ready), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  lif_param_serializer #(.NUM_BYTES(4), .BIT_DIV(3), .ACK_TIMEOUT(64)) dut_b (
    .clk(clk), .reset(reset), .frame_data(frame_data_b), .frame_valid(frame_valid_b),
    .frame_ready(frame_ready_b), .abort(abort_b), .load_mode(load_mode_b), .serial_data(serial_data_b),
    .params_ready(params_ready_b), .busy(busy_b), .done(done_b), .timeout_err(timeout_err_b)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  bit sb[$];

  always @(negedge clk) begin
    if (load_mode === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra_bit: got serial_data=%0b with load_mode high, expected no bit pending", serial_data);
      end else begin
        chk("sb_serial_bit", serial_data, sb.pop_front());
      end
    end
  end

  // Queues the first n bits of f (MSB first) as expected output, then performs the handshake.
  // On return the bench is at the negedge of SHIFT cycle 0.
  task automatic send_frame(input logic [31:0] f, input int n);
    int w = 0;
    while (frame_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("frame_ready_before_send", frame_ready, 1);
    for (int i = 0; i < n; i++) sb.push_back(f[31-i]);
    frame_data  = f;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    chk("load_mode_after_accept", load_mode, 1);
    chk("frame_ready_after_accept", frame_ready, 0);
    chk("busy_after_accept", busy, 1);
    chk("timeout_err_cleared_on_accept", timeout_err, 0);
  endtask

  typedef struct {
    logic [31:0] frame;
    int          ack_delay;   // WAIT_ACK cycle in which params_ready rises; -1 means it never rises
    int          exp_done;
    logic        exp_err;
    int          exp_idle_t;  // WAIT_ACK cycle in which frame_ready is back high
  } vec_t;

  task automatic run_vec(input vec_t v);
    int lm = 0;
    int t = 0;
    int done_cnt = 0;
    int idle_t = -1;
    logic err = 1'b0;
    send_frame(v.frame, 32);
    while (load_mode === 1'b1 && lm < 400) begin
      lm++;
      @(negedge clk);
    end
    chk("load_mode_len", lm, 32);
    chk("wait_ack_busy", busy, 1);
    chk("wait_ack_frame_ready", frame_ready, 0);
    chk("wait_ack_serial_low", serial_data, 0);
    while (t < 200) begin
      if (t == v.ack_delay) params_ready = 1'b1;
      @(negedge clk);
      t++;
      if (done === 1'b1) done_cnt++;
      if (frame_ready === 1'b1) begin
        idle_t = t;
        err    = timeout_err;
        break;
      end
    end
    params_ready = 1'b0;
    chk("idle_return_cycle", idle_t, v.exp_idle_t);
    chk("done_count", done_cnt, v.exp_done);
    chk("timeout_err", err, v.exp_err);
    @(negedge clk);
    chk("done_single_cycle", done, 0);
    chk("timeout_err_sticky", timeout_err, v.exp_err);
    chk("sb_drained", sb.size(), 0);
  endtask

  vec_t vecs[5];

  initial begin
    int c;
    int bad;
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion within the time limit");
    $fatal(1);
  end

  initial begin
    int c;
    int bad;
    vecs[0] = '{32'hA53C0F81,  3, 1, 1'b0,  4};
    vecs[1] = '{32'h12345678, -1, 0, 1'b1, 64};  // no acknowledge: timeout
    vecs[2] = '{32'hFFFFFFFF,  0, 1, 1'b0,  1};  // accepting this frame clears the error
    vecs[3] = '{32'h0F0F0F0F, 63, 1, 1'b0, 64};  // ack and timeout on the same edge
    vecs[4] = '{32'h80000001, 10, 1, 1'b0, 11};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_load_mode", load_mode, 0);
    chk("rst_serial_data", serial_data, 0);
    chk("rst_frame_ready", frame_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout_err", timeout_err, 0);

    // BIT_DIV=3 instance: each bit is held for 3 cycles.
    frame_data_b  = 32'h80000001;
    frame_valid_b = 1'b1;
    @(negedge clk);
    frame_valid_b = 1'b0;
    c   = 0;
    bad = 0;
    while (load_mode_b === 1'b1 && c < 400) begin
      if (serial_data_b !== ((c < 3) || (c >= 93))) bad++;
      c++;
      @(negedge clk);
    end
    chk("div3_load_mode_len", c, 96);
    chk("div3_serial_pattern_errors", bad, 0);
    params_ready_b = 1'b1;
    @(negedge clk);
    params_ready_b = 1'b0;
    chk("div3_done", done_b, 1);
    chk("div3_frame_ready", frame_ready_b, 1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort at bit 10, followed by a stale acknowledge.
    send_frame(32'hC3A55A3C, 11);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_load_mode", load_mode, 0);
    chk("abort_frame_ready", frame_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", timeout_err, 0);
    chk("abort_sb_drained", sb.size(), 0);
    params_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stale_ack_no_done", done, 0);
      chk("stale_ack_ready", frame_ready, 1);
    end
    params_ready = 1'b0;

    // Abort on the same edge as the last-bit transition: WAIT_ACK is never entered.
    send_frame(32'h6B2D19E7, 32);
    repeat (31) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_last_load_mode", load_mode, 0);
    chk("abort_last_frame_ready", frame_ready, 1);
    chk("abort_last_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("abort_last_no_done", done, 0);
    chk("abort_last_no_err", timeout_err, 0);

    // Abort while IDLE has no effect.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_ready", frame_ready, 1);
    chk("idle_abort_busy", busy, 0);

    // Reset at bit 20 while a second frame is offered during busy.
    send_frame(32'h13579BDF, 21);
    frame_data  = 32'hFFFF0000;
    frame_valid = 1'b1;
    repeat (20) @(negedge clk);
    chk("busy_offer_not_ready", frame_ready, 0);
    reset       = 1'b1;
    frame_valid = 1'b0;
    @(negedge clk);
    chk("midrst_load_mode", load_mode, 0);
    chk("midrst_serial_data", serial_data, 0);
    chk("midrst_frame_ready", frame_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", timeout_err, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_retransmit", load_mode, 0);
    chk("midrst_sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
